// File: rtl/frame_draw_arbiter_if.sv
// Bundle between the three drawing engines and the VGA plot port:
// per-requester handshake and pixel buses in, arbitrated pixel bus and pass status out.
interface frame_draw_arbiter_if #(
  parameter int X_W   = 8,
  parameter int Y_W   = 7,
  parameter int COL_W = 3
);
  logic               frame_tick;
  logic [2:0]         req;
  logic [2:0]         done;
  logic [3*X_W-1:0]   pix_x_in;
  logic [3*Y_W-1:0]   pix_y_in;
  logic [3*COL_W-1:0] pix_c_in;
  logic [2:0]         plot_in;
  logic [2:0]         grant;
  logic [X_W-1:0]     vga_x;
  logic [Y_W-1:0]     vga_y;
  logic [COL_W-1:0]   vga_colour;
  logic               vga_plot;
  logic               frame_busy;
  logic               frame_done;
  logic [1:0]         cur_slot;
  logic               overrun_err;
  logic               timeout_err;

  modport master (
    output frame_tick, req, done, pix_x_in, pix_y_in, pix_c_in, plot_in,
    input  grant, vga_x, vga_y, vga_colour, vga_plot,
           frame_busy, frame_done, cur_slot, overrun_err, timeout_err
  );

  modport slave (
    input  frame_tick, req, done, pix_x_in, pix_y_in, pix_c_in, plot_in,
    output grant, vga_x, vga_y, vga_colour, vga_plot,
           frame_busy, frame_done, cur_slot, overrun_err, timeout_err
  );
endinterface

// File: rtl/frame_draw_arbiter.sv
// One fixed-order draw pass per frame tick (erase, walls, bird), each requester granted the
// VGA plot port at most once per pass; the granted pixel bus is registered onto the VGA inputs.
module frame_draw_arbiter #(
  parameter int X_W        = 8,
  parameter int Y_W        = 7,
  parameter int COL_W      = 3,
  parameter int MAX_CYCLES = 20000
) (
  input logic                 clk,
  input logic                 resetn,
  frame_draw_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SCAN, GRANT, GAP} state_t;

  state_t             state_q, state_d;
  logic [1:0]         slot_q, slot_d;
  logic [2:0]         grant_q, grant_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               fdone_q, fdone_d;
  logic               ovr_q, ovr_d;
  logic               tmo_q, tmo_d;
  logic [X_W-1:0]     vga_x_q, vga_x_d;
  logic [Y_W-1:0]     vga_y_q, vga_y_d;
  logic [COL_W-1:0]   vga_c_q, vga_c_d;
  logic               vga_plot_q, vga_plot_d;

  // Slot 3 never occurs; the spare entry keeps the slot-indexed mux in range.
  logic [X_W-1:0]   x_arr [4];
  logic [Y_W-1:0]   y_arr [4];
  logic [COL_W-1:0] c_arr [4];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_unpack
      assign x_arr[gi] = bus.pix_x_in[gi*X_W +: X_W];
      assign y_arr[gi] = bus.pix_y_in[gi*Y_W +: Y_W];
      assign c_arr[gi] = bus.pix_c_in[gi*COL_W +: COL_W];
    end
  endgenerate
  assign x_arr[3] = '0;
  assign y_arr[3] = '0;
  assign c_arr[3] = '0;

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    fdone_d = 1'b0;
    tmo_d   = tmo_q;
    // A tick is only honoured from IDLE; any tick seen while busy is an overrun.
    ovr_d   = ovr_q | (bus.frame_tick & busy_q);

    case (state_q)
      IDLE: begin
        if (bus.frame_tick) begin
          state_d = SCAN;
          slot_d  = 2'd0;
          busy_d  = 1'b1;
        end
      end
      SCAN: begin
        if (bus.req[slot_q]) begin
          state_d = GRANT;
          grant_d = 3'b001 << slot_q;
          cnt_d   = '0;
        end else if (slot_q == 2'd2) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          fdone_d = 1'b1;
        end else begin
          slot_d = slot_q + 2'd1;
        end
      end
      GRANT: begin
        cnt_d = cnt_q + 1'b1;
        // done wins over a simultaneous timeout.
        if (bus.done[slot_q]) begin
          state_d = GAP;
          grant_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = GAP;
          grant_d = '0;
          tmo_d   = 1'b1;
        end
      end
      GAP: begin
        cnt_d = '0;
        if (slot_q == 2'd2) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          fdone_d = 1'b1;
        end else begin
          state_d = SCAN;
          slot_d  = slot_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    vga_x_d    = vga_x_q;
    vga_y_d    = vga_y_q;
    vga_c_d    = vga_c_q;
    vga_plot_d = |(bus.plot_in & grant_q);
    if (grant_q != 3'b000) begin
      vga_x_d = x_arr[slot_q];
      vga_y_d = y_arr[slot_q];
      vga_c_d = c_arr[slot_q];
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q    <= IDLE;
      slot_q     <= 2'd0;
      grant_q    <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      fdone_q    <= 1'b0;
      ovr_q      <= 1'b0;
      tmo_q      <= 1'b0;
      vga_x_q    <= '0;
      vga_y_q    <= '0;
      vga_c_q    <= '0;
      vga_plot_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      grant_q    <= grant_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      fdone_q    <= fdone_d;
      ovr_q      <= ovr_d;
      tmo_q      <= tmo_d;
      vga_x_q    <= vga_x_d;
      vga_y_q    <= vga_y_d;
      vga_c_q    <= vga_c_d;
      vga_plot_q <= vga_plot_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.vga_x       = vga_x_q;
  assign bus.vga_y       = vga_y_q;
  assign bus.vga_colour  = vga_c_q;
  assign bus.vga_plot    = vga_plot_q;
  assign bus.frame_busy  = busy_q;
  assign bus.frame_done  = fdone_q;
  assign bus.cur_slot    = slot_q;
  assign bus.overrun_err = ovr_q;
  assign bus.timeout_err = tmo_q;
endmodule

// File: tb/tb_frame_draw_arbiter.sv
// Directed bench: whole stimulus and expected-output timeline is precomputed from the pass rules,
// then replayed cycle by cycle while one process compares every DUT output each cycle.
module tb_frame_draw_arbiter;
  localparam int N    = 1024;
  localparam int MAXC = 8;

  localparam int F_GRANT = 0, F_BUSY = 1, F_FDONE = 2, F_TMO = 3, F_OVR = 4;
  localparam int F_VX = 5, F_VY = 6, F_VC = 7, F_VPLOT = 8, F_SLOT = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;
  int   n_end = 0;
  int   ncur = 0;
  bit   built = 1'b0;

  frame_draw_arbiter_if #(.X_W(8), .Y_W(7), .COL_W(3)) bus ();

  frame_draw_arbiter #(.X_W(8), .Y_W(7), .COL_W(3), .MAX_CYCLES(MAXC)) dut (
    .clk   (clk),
    .resetn(rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stimulus for cycle n is applied after edge n; expectations at n are outputs after edge n.
  logic        st_tick [N];
  logic        st_rst  [N];
  logic [2:0]  st_req  [N];
  logic [2:0]  st_done [N];
  logic [2:0]  st_plot [N];
  logic [23:0] st_px   [N];
  logic [20:0] st_py   [N];
  logic [8:0]  st_pc   [N];

  logic [2:0]  ex_grant [N];
  logic        ex_busy  [N];
  logic        ex_fdone [N];
  logic [1:0]  ex_slot  [N];
  logic        ex_tmo   [N];
  logic        ex_ovr   [N];
  logic        tmo_evt  [N];
  logic [7:0]  ex_vx    [N];
  logic [6:0]  ex_vy    [N];
  logic [2:0]  ex_vc    [N];
  logic        ex_vplot [N];

  typedef struct {
    int cyc;
    int fld;
    int val;
  } lit_t;
  lit_t lits[$];

  task automatic add_lit(input int c, input int f, input int v);
    lit_t l;
    l.cyc = c; l.fld = f; l.val = v;
    lits.push_back(l);
  endtask

  task automatic set_exp(input int n, input logic [2:0] g, input logic b, input logic fd,
                         input logic [1:0] s);
    ex_grant[n] = g; ex_busy[n] = b; ex_fdone[n] = fd; ex_slot[n] = s;
  endtask

  task automatic idle(input int k);
    for (int j = 0; j < k; j++) begin
      set_exp(ncur + 1, 3'b000, 1'b0, 1'b0, ex_slot[ncur]);
      ncur++;
    end
  endtask

  task automatic reset_cycles(input int k);
    for (int j = 0; j < k; j++) begin
      st_rst[ncur] = 1'b1;
      set_exp(ncur + 1, 3'b000, 1'b0, 1'b0, 2'd0);
      ncur++;
    end
  endtask

  // l[i] = cycles until done (0 = never). tick2: extra tick offset (0 none, -1 = last busy cycle).
  // abort_k: reset lands at that relative edge (0 = no reset).
  task automatic run_pass(input logic [2:0] r, input int l0, input int l1, input int l2,
                          input int tick2, input int abort_k, output int e0);
    int ls[3];
    int p, h, d, t2;
    bit normal;
    ls[0] = l0; ls[1] = l1; ls[2] = l2;
    e0 = ncur + 1;
    st_tick[ncur] = 1'b1;
    set_exp(e0, 3'b000, 1'b1, 1'b0, 2'd0);
    p = 0;
    d = 0;
    for (int i = 0; i < 3; i++) begin
      if (r[i]) begin
        normal = (ls[i] >= 1) && (ls[i] <= MAXC);
        h = normal ? ls[i] : MAXC;
        for (int k = p + 1; k <= p + h; k++) begin
          set_exp(e0 + k, 3'(1 << i), 1'b1, 1'b0, 2'(i));
          st_done[e0 + k] = 3'((e0 + k) * 3 + 1) & ~3'(1 << i);
        end
        if (normal) st_done[e0 + p + ls[i]][i] = 1'b1;
        set_exp(e0 + p + h + 1, 3'b000, 1'b1, 1'b0, 2'(i));
        tmo_evt[e0 + p + h + 1] = !normal;
        p = p + h + 2;
      end else begin
        p = p + 1;
      end
      if (i == 2) begin
        set_exp(e0 + p, 3'b000, 1'b0, 1'b1, 2'd2);
        d = p;
      end else begin
        set_exp(e0 + p, 3'b000, 1'b1, 1'b0, 2'(i + 1));
      end
    end
    // The granted requester drops its request mid-grant; the grant must hold regardless.
    for (int k = 0; k < d; k++) st_req[e0 + k] = r & ~ex_grant[e0 + k];
    t2 = (tick2 == -1) ? d - 1 : tick2;
    if (t2 != 0) st_tick[e0 + t2] = 1'b1;
    if (abort_k > 0) begin
      st_rst[e0 + abort_k - 1] = 1'b1;
      for (int k = abort_k; k <= d; k++) begin
        st_done[e0 + k] = 3'b000; st_req[e0 + k] = 3'b000;
        st_tick[e0 + k] = 1'b0;   tmo_evt[e0 + k] = 1'b0;
      end
      set_exp(e0 + abort_k, 3'b000, 1'b0, 1'b0, 2'd0);
      ncur = e0 + abort_k;
    end else begin
      ncur = e0 + d;
    end
  endtask

  task automatic build();
    int a, b, c, d, e, f, g, h;
    int s;
    for (int n = 0; n < N; n++) begin
      st_tick[n] = 0; st_rst[n] = 0; st_req[n] = 0; st_done[n] = 0;
      st_plot[n] = 3'(n * 5) ^ 3'(n >> 2);
      for (int i = 0; i < 3; i++) begin
        st_px[n][i*8 +: 8] = 8'(n * 13 + i * 71);
        st_py[n][i*7 +: 7] = 7'(n * 5 + i * 37);
        st_pc[n][i*3 +: 3] = 3'(n + i * 3);
      end
      set_exp(n, 3'b000, 1'b0, 1'b0, 2'd0);
      ex_tmo[n] = 0; ex_ovr[n] = 0; tmo_evt[n] = 0;
      ex_vx[n] = 0; ex_vy[n] = 0; ex_vc[n] = 0; ex_vplot[n] = 0;
    end

    reset_cycles(3);
    add_lit(ncur, F_GRANT, 0); add_lit(ncur, F_BUSY, 0); add_lit(ncur, F_VPLOT, 0);
    idle(2);

    run_pass(3'b111, 5, 5, 5, 0, 0, a);
    add_lit(a + 1, F_GRANT, 1);  add_lit(a + 5, F_GRANT, 1);  add_lit(a + 6, F_GRANT, 0);
    add_lit(a + 8, F_GRANT, 2);  add_lit(a + 15, F_GRANT, 4); add_lit(a + 20, F_BUSY, 1);
    add_lit(a + 21, F_FDONE, 1); add_lit(a + 21, F_BUSY, 0);
    idle(3);

    run_pass(3'b100, 0, 0, 4, 0, 0, b);
    for (int n = b; n < b + 9; n++) begin
      if (ex_grant[n] == 3'b100) begin
        st_px[n] = {8'd55, st_px[n][15:8], 8'd10};
        st_py[n][20:14] = 7'd30;
        st_pc[n][8:6] = 3'b110;
        st_plot[n] = 3'b101;
      end
    end
    add_lit(b + 2, F_GRANT, 0); add_lit(b + 3, F_GRANT, 4);
    add_lit(b + 4, F_VX, 55);   add_lit(b + 4, F_VY, 30); add_lit(b + 4, F_VC, 6);
    add_lit(b + 4, F_VPLOT, 1); add_lit(b + 8, F_FDONE, 1);
    add_lit(b + 8, F_VX, 55);   add_lit(b + 8, F_VPLOT, 0);
    idle(2);

    run_pass(3'b111, 2, 0, 2, 0, 0, c);
    add_lit(c + 12, F_GRANT, 2); add_lit(c + 12, F_TMO, 0); add_lit(c + 13, F_GRANT, 0);
    add_lit(c + 13, F_TMO, 1);   add_lit(c + 15, F_GRANT, 4); add_lit(c + 18, F_FDONE, 1);
    idle(2);
    reset_cycles(2);
    idle(2);

    run_pass(3'b010, 0, MAXC, 0, 0, 0, d);
    add_lit(d + 9, F_GRANT, 2); add_lit(d + 10, F_GRANT, 0);
    add_lit(d + 10, F_TMO, 0);  add_lit(d + 12, F_FDONE, 1);
    idle(2);

    run_pass(3'b111, 3, 3, 3, 5, 0, e);
    add_lit(e + 5, F_OVR, 0); add_lit(e + 6, F_OVR, 1);
    add_lit(e + 6, F_GRANT, 2); add_lit(e + 15, F_FDONE, 1);
    idle(2);

    run_pass(3'b011, 1, 2, 0, -1, 0, f);
    add_lit(f + 8, F_FDONE, 1); add_lit(f + 9, F_BUSY, 0); add_lit(f + 9, F_OVR, 1);
    idle(2);

    run_pass(3'b111, 3, 6, 3, 0, 8, g);
    add_lit(g + 7, F_GRANT, 2); add_lit(g + 8, F_GRANT, 0); add_lit(g + 8, F_BUSY, 0);
    add_lit(g + 8, F_OVR, 0);   add_lit(g + 8, F_VPLOT, 0); add_lit(g + 8, F_SLOT, 0);
    idle(2);

    run_pass(3'b111, 2, 2, 2, 0, 0, h);
    add_lit(h, F_SLOT, 0); add_lit(h + 1, F_GRANT, 1);
    idle(3);
    n_end = ncur;

    // VGA register, sticky flags: forward evaluation over the timeline.
    for (int n = 1; n <= n_end; n++) begin
      if (st_rst[n-1]) begin
        ex_vx[n] = 0; ex_vy[n] = 0; ex_vc[n] = 0; ex_vplot[n] = 0;
        ex_ovr[n] = 0; ex_tmo[n] = 0;
      end else begin
        if (ex_grant[n-1] != 3'b000) begin
          s = ex_grant[n-1][0] ? 0 : (ex_grant[n-1][1] ? 1 : 2);
          ex_vx[n] = st_px[n-1][s*8 +: 8];
          ex_vy[n] = st_py[n-1][s*7 +: 7];
          ex_vc[n] = st_pc[n-1][s*3 +: 3];
          ex_vplot[n] = st_plot[n-1][s];
        end else begin
          ex_vx[n] = ex_vx[n-1]; ex_vy[n] = ex_vy[n-1]; ex_vc[n] = ex_vc[n-1];
          ex_vplot[n] = 1'b0;
        end
        ex_ovr[n] = ex_ovr[n-1] | (st_tick[n-1] & ex_busy[n-1]);
        ex_tmo[n] = ex_tmo[n-1] | tmo_evt[n];
      end
    end
  endtask

  task automatic apply(input int n);
    rst            = st_rst[n];
    bus.frame_tick = st_tick[n];
    bus.req        = st_req[n];
    bus.done       = st_done[n];
    bus.plot_in    = st_plot[n];
    bus.pix_x_in   = st_px[n];
    bus.pix_y_in   = st_py[n];
    bus.pix_c_in   = st_pc[n];
  endtask

  task automatic chk(input string nm, input int act, input int want);
    n_checks++;
    if (act != want) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, act, want);
    end
  endtask

  function automatic int dut_field(input int f);
    case (f)
      F_GRANT: return int'(bus.grant);
      F_BUSY:  return int'(bus.frame_busy);
      F_FDONE: return int'(bus.frame_done);
      F_TMO:   return int'(bus.timeout_err);
      F_OVR:   return int'(bus.overrun_err);
      F_VX:    return int'(bus.vga_x);
      F_VY:    return int'(bus.vga_y);
      F_VC:    return int'(bus.vga_colour);
      F_VPLOT: return int'(bus.vga_plot);
      default: return int'(bus.cur_slot);
    endcase
  endfunction

  always @(negedge clk) begin
    if (built && cyc >= 1 && cyc <= n_end) begin
      chk("grant",       int'(bus.grant),       int'(ex_grant[cyc]));
      chk("frame_busy",  int'(bus.frame_busy),  int'(ex_busy[cyc]));
      chk("frame_done",  int'(bus.frame_done),  int'(ex_fdone[cyc]));
      chk("cur_slot",    int'(bus.cur_slot),    int'(ex_slot[cyc]));
      chk("timeout_err", int'(bus.timeout_err), int'(ex_tmo[cyc]));
      chk("overrun_err", int'(bus.overrun_err), int'(ex_ovr[cyc]));
      chk("vga_x",       int'(bus.vga_x),       int'(ex_vx[cyc]));
      chk("vga_y",       int'(bus.vga_y),       int'(ex_vy[cyc]));
      chk("vga_colour",  int'(bus.vga_colour),  int'(ex_vc[cyc]));
      chk("vga_plot",    int'(bus.vga_plot),    int'(ex_vplot[cyc]));
      foreach (lits[j]) begin
        if (lits[j].cyc == cyc) chk($sformatf("literal_f%0d", lits[j].fld),
                                    dut_field(lits[j].fld), lits[j].val);
      end
      if (bus.frame_done)
        $display("pass end cycle %0d overrun_err=%0d timeout_err=%0d",
                 cyc, bus.overrun_err, bus.timeout_err);
    end
  end

  initial begin
    build();
    built = 1'b1;
    apply(0);
    while (cyc < n_end) begin
      @(posedge clk);
      #1;
      apply(cyc);
    end
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
